// File: rtl/iomem_wb_bridge_if.sv
// iomem_wb_bridge_if: PicoRV32 iomem, EFB Wishbone and timeout status signals of the bridge
interface iomem_wb_bridge_if;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i;
  logic        to_err;
  logic [7:0]  to_count;
  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, wb_dat_i, wb_ack_i,
    output iomem_ready, iomem_rdata, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, to_err, to_count
  );
  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, wb_dat_i, wb_ack_i,
    input  iomem_ready, iomem_rdata, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, to_err, to_count
  );
endinterface

// File: rtl/iomem_wb_bridge.sv
// iomem_wb_bridge: PicoRV32 iomem window to single 8-bit Wishbone classic cycles with bus timeout
module iomem_wb_bridge #(
  parameter logic [7:0]  BASE_HI  = 8'h04,
  parameter logic [15:0] TIMEOUT  = 16'd255,
  parameter logic [31:0] ERR_DATA = 32'h00BADADD
) (
  input logic clk,
  input logic resetn,
  iomem_wb_bridge_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
  logic [1:0]  r_state;
  logic [15:0] r_timer;
  logic        r_stb, r_we, r_cool, r_to_err;
  logic [7:0]  r_adr, r_dat, r_to_count;
  logic [31:0] r_rdata;
  logic        w_match, w_skip, w_expire, w_ready, w_unused;
  assign w_match  = bus.iomem_valid && bus.iomem_addr[31:24] == BASE_HI;
  assign w_skip   = |bus.iomem_wstrb && !bus.iomem_wstrb[0];
  assign w_expire = r_timer == TIMEOUT - 16'd1;
  assign w_ready  = r_state == RESP;
  assign w_unused = &{1'b0, bus.iomem_addr[23:10], bus.iomem_addr[1:0], bus.iomem_wdata[31:8]};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_cool     <= 1'b0;
      r_to_err   <= 1'b0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_to_count <= '0;
      r_rdata    <= '0;
    end else begin
      r_to_err <= 1'b0;
      r_cool   <= 1'b0;
      case (r_state)
        IDLE:
          // r_cool blocks the CPU's still-held request right after its own RESP
          if (w_match && !r_cool) begin
            if (w_skip) begin
              r_rdata <= '0;
              r_state <= RESP;
            end else begin
              r_adr   <= bus.iomem_addr[9:2];
              r_dat   <= bus.iomem_wdata[7:0];
              r_we    <= |bus.iomem_wstrb;
              r_stb   <= 1'b1;
              r_timer <= '0;
              r_state <= REQ;
            end
          end
        REQ:
          if (!bus.iomem_valid) begin
            r_stb   <= 1'b0;
            r_state <= IDLE;
          end else if (bus.wb_ack_i) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_rdata <= r_we ? 32'h0 : {24'h0, bus.wb_dat_i};
            r_state <= RESP;
          end else if (w_expire) begin
            r_stb      <= 1'b0;
            r_rdata    <= r_we ? 32'h0 : ERR_DATA;
            r_to_err   <= 1'b1;
            r_to_count <= r_to_count + 8'(r_to_count != 8'hFF);
            r_state    <= RESP;
          end else
            r_timer <= r_timer + 16'd1;
        default: begin
          r_cool  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  assign bus.iomem_ready = w_ready;
  assign bus.iomem_rdata = w_ready ? r_rdata : 32'h0;
  assign bus.wb_cyc_o    = r_stb;
  assign bus.wb_stb_o    = r_stb;
  assign bus.wb_we_o     = r_we;
  assign bus.wb_adr_o    = r_adr;
  assign bus.wb_dat_o    = r_dat;
  assign bus.to_err      = r_to_err;
  assign bus.to_count    = r_to_count;
endmodule

// File: tb/tb_iomem_wb_bridge.sv
// tb_iomem_wb_bridge: directed vectors, expected responses queued and checked by a ready monitor
module tb_iomem_wb_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0, failures = 0;
  logic [40:0] exp_q[$];
  string name_q[$];
  int sl_delay = -1, sl_cnt = 0;
  logic [7:0] sl_data = 8'h00;
  logic sl_force = 1'b0;
  int stb_cycles, exp_cnt = 0, rdy_seen, stb_seen;
  logic got_ready, cyc_bad = 1'b0;
  logic [7:0] s_adr, s_dat;
  logic s_we;
  iomem_wb_bridge_if bus ();
  iomem_wb_bridge #(.TIMEOUT(16'd16)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic expect_resp(input string n, input logic err, input logic [31:0] rdata);
    if (err) exp_cnt = exp_cnt < 255 ? exp_cnt + 1 : 255;
    exp_q.push_back({err, 8'(exp_cnt), rdata});
    name_q.push_back(n);
  endtask
  always @(negedge clk) begin
    if (sl_force) bus.wb_ack_i = 1'b1;
    else if (!bus.wb_stb_o) begin
      sl_cnt = 0;
      bus.wb_ack_i = 1'b0;
    end else begin
      bus.wb_ack_i = (sl_cnt == sl_delay);
      sl_cnt++;
    end
    bus.wb_dat_i = sl_data;
    if (bus.wb_cyc_o !== bus.wb_stb_o) cyc_bad = 1'b1;
  end
  always @(negedge clk)
    if (resetn && bus.iomem_ready) begin
      if (exp_q.size() == 0) check("unexpected_ready", bus.iomem_rdata, 32'hFFFF_FFFF);
      else begin
        logic [40:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, "_rdata"}, bus.iomem_rdata, e[31:0]);
        check({n, "_to_err"}, 32'(bus.to_err), 32'(e[40]));
        check({n, "_to_count"}, 32'(bus.to_count), 32'(e[39:32]));
      end
    end
  task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int dl, input logic [7:0] sd);
    sl_delay = dl;
    sl_data = sd;
    stb_cycles = 0;
    got_ready = 1'b0;
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr = a;
    bus.iomem_wstrb = s;
    bus.iomem_wdata = d;
    for (int n = 0; n < 400 && !got_ready; n++) begin
      @(negedge clk);
      if (bus.wb_stb_o) begin
        if (stb_cycles == 0) begin
          s_adr = bus.wb_adr_o;
          s_dat = bus.wb_dat_o;
          s_we = bus.wb_we_o;
        end
        stb_cycles++;
      end
      if (bus.iomem_ready) got_ready = 1'b1;
    end
    if (!got_ready) check("ready_wait", 32'(got_ready), 32'd1);
    @(posedge clk);
    #1 bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
  endtask
  initial begin
    #1_000_000 $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_addr = 32'h0;
    bus.iomem_wdata = 32'h0;
    #22;
    check("reset_outputs", {bus.iomem_ready, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.to_err, bus.wb_adr_o, bus.wb_dat_o, bus.to_count}, 32'h0);
    check("reset_rdata", bus.iomem_rdata, 32'h0);
    @(negedge clk) resetn = 1'b1;
    expect_resp("read5a", 1'b0, 32'h0000_005A);
    issue(32'h0400_0028, 4'h0, 32'h0, 2, 8'h5A);
    check("read5a_adr", 32'(s_adr), 32'h0A);
    check("read5a_we", 32'(s_we), 32'd0);
    check("read5a_stb_cycles", stb_cycles, 3);
    expect_resp("write", 1'b0, 32'h0);
    issue(32'h0400_0004, 4'hF, 32'h1234_56C3, 0, 8'hEE);
    check("write_we", 32'(s_we), 32'd1);
    check("write_dat", 32'(s_dat), 32'hC3);
    check("write_adr", 32'(s_adr), 32'h01);
    expect_resp("skip", 1'b0, 32'h0);
    issue(32'h0400_0000, 4'b0010, 32'hFFFF_FFFF, 0, 8'h77);
    check("skip_stb_cycles", stb_cycles, 0);
    rdy_seen = 0;
    stb_seen = 0;
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr = 32'h0100_0000;
    repeat (10) begin
      @(negedge clk);
      rdy_seen += 32'(bus.iomem_ready);
      stb_seen += 32'(bus.wb_stb_o);
    end
    bus.iomem_valid = 1'b0;
    check("nomatch_ready", rdy_seen, 0);
    check("nomatch_stb", stb_seen, 0);
    expect_resp("timeout_read", 1'b1, 32'h00BA_DADD);
    issue(32'h0400_0010, 4'h0, 32'h0, -1, 8'h00);
    check("timeout_stb_cycles", stb_cycles, 16);
    expect_resp("ack_at_expiry", 1'b0, 32'h0000_0096);
    issue(32'h0400_0014, 4'h0, 32'h0, 15, 8'h96);
    check("ack_at_expiry_stb_cycles", stb_cycles, 16);
    sl_delay = -1;
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr = 32'h0400_0008;
    bus.iomem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    bus.iomem_valid = 1'b0;
    @(posedge clk);
    #1 sl_force = 1'b1;
    @(posedge clk);
    #1 sl_force = 1'b0;
    rdy_seen = 0;
    stb_seen = 0;
    repeat (6) begin
      @(negedge clk);
      rdy_seen += 32'(bus.iomem_ready);
      stb_seen += 32'(bus.wb_stb_o);
    end
    check("abort_ready", rdy_seen, 0);
    check("abort_stb", stb_seen, 0);
    expect_resp("after_abort", 1'b0, 32'h0000_0033);
    issue(32'h0400_00FC, 4'h0, 32'h0, 1, 8'h33);
    check("after_abort_adr", 32'(s_adr), 32'h3F);
    for (int i = 0; i < 299; i++) begin
      expect_resp("timeout_sat", 1'b1, 32'h00BA_DADD);
      issue(32'h0400_0010, 4'h0, 32'h0, -1, 8'h00);
    end
    check("to_count_saturated", 32'(bus.to_count), 32'd255);
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr = 32'h0400_0030;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'h0000_00A5;
    repeat (4) @(negedge clk);
    check("midreq_stb_before_reset", 32'(bus.wb_stb_o), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midreq_reset_outputs", {bus.iomem_ready, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.to_err, bus.wb_adr_o, bus.wb_dat_o, bus.to_count}, 32'h0);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    exp_cnt = 0;
    @(negedge clk) resetn = 1'b1;
    expect_resp("after_reset", 1'b0, 32'h0000_0042);
    issue(32'h0400_0020, 4'h0, 32'h0, 0, 8'h42);
    repeat (3) @(negedge clk);
    check("cyc_equals_stb", 32'(cyc_bad), 32'd0);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
